mem_map_ctrl: RTL and testbench

MEM_MAP_CTRL -- requirements
Module: mem_map_ctrl

---
 rtl/mem_map_pkg.sv | 25 ++
 rtl/mem_map_decode.sv | 23 ++
 rtl/mem_map_ctrl.sv | 119 +++++++++++
 tb/tb_mem_map_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared types for the memory-map controller and the bus blocks that reuse its decoder.
package mem_map_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_IO
    } region_t;

    // Counter width able to hold the larger of the two wait values (never narrower than 1 bit).
    function automatic int waitWidth(input int romWait, input int ramWait);
        int maxWait;
        maxWait = (romWait > ramWait) ? romWait : ramWait;
        return (maxWait < 1) ? 1 : $clog2(maxWait + 1);
    endfunction

    localparam int WAIT_W = waitWidth(1, 0);

endpackage

// File: rtl/mem_map_decode.sv
// Combinational address decoder: IO register address wins, then the ROM window, then RAM.
module mem_map_decode
    import mem_map_pkg::*;
#(
    parameter int              ADDR_W       = 16,
    parameter int              ROM_SEL_BITS = 3,
    parameter logic [ADDR_W-1:0] IO_ADDR    = 16'hFFFF
) (
    input  logic [ADDR_W-1:0] i_addr,
    output region_t           o_region
);

    always_comb begin
        if (i_addr == IO_ADDR) begin
            o_region = REG_IO;
        end else if (i_addr[ADDR_W-1 -: ROM_SEL_BITS] == '0) begin
            o_region = REG_ROM;
        end else begin
            o_region = REG_RAM;
        end
    end

endmodule

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: one access at a time through IDLE -> WAIT -> DONE, with a banked RAM
// window, a write-protected ROM window and a single bank-select register.
module mem_map_ctrl
    import mem_map_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 16,
    parameter int                ROM_SEL_BITS = 3,
    parameter int                BANK_W       = 2,
    parameter int                ROM_WAIT     = 1,
    parameter int                RAM_WAIT     = 0,
    parameter logic [ADDR_W-1:0] IO_ADDR      = 16'hFFFF
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     REQ,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        ADDR,
    input  logic [DATA_W-1:0]        D_IN,
    output logic [DATA_W-1:0]        D_OUT,
    output logic                     ACK,
    output logic                     ERR,
    output logic [ADDR_W-1:0]        ROM_A,
    input  logic [DATA_W-1:0]        ROM_D,
    output logic [BANK_W+ADDR_W-1:0] RAM_A,
    output logic [DATA_W-1:0]        RAM_X,
    output logic                     RAM_ST,
    input  logic [DATA_W-1:0]        RAM_Q
);

    localparam int CNT_W = waitWidth(ROM_WAIT, RAM_WAIT);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_data;
    region_t             r_region;
    logic [DATA_W-1:0]   r_dout;
    logic [BANK_W-1:0]   r_bank;

    region_t             w_region;
    logic [CNT_W-1:0]    w_waitLoad;

    mem_map_decode #(
        .ADDR_W      (ADDR_W),
        .ROM_SEL_BITS(ROM_SEL_BITS),
        .IO_ADDR     (IO_ADDR)
    ) u_decode (
        .i_addr  (ADDR),
        .o_region(w_region)
    );

    always_comb begin
        case (w_region)
            REG_ROM: w_waitLoad = CNT_W'(ROM_WAIT);
            REG_RAM: w_waitLoad = CNT_W'(RAM_WAIT);
            default: w_waitLoad = '0;
        endcase
    end

    // Everything the outputs depend on is latched at accept time, so bus inputs may wander mid-access.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_data   <= '0;
            r_region <= REG_ROM;
            r_dout   <= '0;
            r_bank   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (REQ) begin
                        r_addr   <= ADDR;
                        r_we     <= WE;
                        r_data   <= D_IN;
                        r_region <= w_region;
                        r_cnt    <= w_waitLoad;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        if (!r_we) begin
                            case (r_region)
                                REG_ROM: r_dout <= ROM_D;
                                REG_RAM: r_dout <= RAM_Q;
                                default: r_dout <= DATA_W'(r_bank);
                            endcase
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (r_we && (r_region == REG_IO)) begin
                        r_bank <= r_data[BANK_W-1:0];
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake strobes are pure decodes of the DONE state, so reset clears them instantly.
    assign ACK    = (r_state == ST_DONE);
    assign ERR    = ACK && r_we && (r_region == REG_ROM);
    assign RAM_ST = ACK && r_we && (r_region == REG_RAM);
    assign D_OUT  = r_dout;
    assign ROM_A  = r_addr;
    assign RAM_A  = {r_bank, r_addr};
    assign RAM_X  = r_data;

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Scoreboard bench for mem_map_ctrl: a driver predicts each access from the memory-map rules,
// a negedge monitor pops and compares whenever ACK is presented.
module tb_mem_map_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BANK_W = 2;

    logic                     CLK;
    logic                     RST_N;
    logic                     REQ;
    logic                     WE;
    logic [ADDR_W-1:0]        ADDR;
    logic [DATA_W-1:0]        D_IN;
    logic [DATA_W-1:0]        D_OUT;
    logic                     ACK;
    logic                     ERR;
    logic [ADDR_W-1:0]        ROM_A;
    logic [DATA_W-1:0]        ROM_D;
    logic [BANK_W+ADDR_W-1:0] RAM_A;
    logic [DATA_W-1:0]        RAM_X;
    logic                     RAM_ST;
    logic [DATA_W-1:0]        RAM_Q;

    mem_map_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ROM_SEL_BITS(3),
        .BANK_W      (BANK_W),
        .ROM_WAIT    (1),
        .RAM_WAIT    (0),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .WE    (WE),
        .ADDR  (ADDR),
        .D_IN  (D_IN),
        .D_OUT (D_OUT),
        .ACK   (ACK),
        .ERR   (ERR),
        .ROM_A (ROM_A),
        .ROM_D (ROM_D),
        .RAM_A (RAM_A),
        .RAM_X (RAM_X),
        .RAM_ST(RAM_ST),
        .RAM_Q (RAM_Q)
    );

    typedef struct {
        int          ackCycle;
        logic [15:0] dout;
        logic        err;
        logic        st;
        logic        isRam;
        logic        isRom;
        logic [17:0] ramA;
        logic [15:0] romA;
        logic [15:0] ramX;
    } exp_t;

    exp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    int          cycleCount = 0;
    bit          dutInDone = 0;
    logic [15:0] modelRam [int];
    logic [1:0]  modelBank = 0;
    logic [15:0] modelDout = 0;
    logic [15:0] ramMem [0:262143];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cycleCount <= cycleCount + 1;

    function automatic logic [15:0] romFn(input logic [15:0] a);
        if (a == 16'h0100) return 16'hBEEF;
        return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
    endfunction

    assign ROM_D = romFn(ROM_A);
    assign RAM_Q = ramMem[RAM_A];
    always @(posedge CLK) if (RAM_ST) ramMem[RAM_A] <= RAM_X;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Reference model: region from address ranges, latency 2 + region wait, data from the bank/ram/rom rules.
    function automatic exp_t predict(input logic we, input logic [15:0] addr, input logic [15:0] data, input int issue);
        exp_t e;
        int   waitCycles;
        int   key;
        e.err   = 0;
        e.st    = 0;
        e.isRam = 0;
        e.isRom = 0;
        e.romA  = addr;
        e.ramX  = data;
        e.ramA  = 18'(modelBank) * 18'h10000 + 18'(addr);
        key     = int'(e.ramA);
        if (addr == 16'hFFFF) begin
            waitCycles = 0;
            if (we) modelBank = 2'(data % 4);
            else    modelDout = 16'(modelBank);
        end else if (addr < 16'h2000) begin
            waitCycles = 1;
            e.isRom = 1;
            if (we) e.err = 1;
            else    modelDout = romFn(addr);
        end else begin
            waitCycles = 0;
            e.isRam = 1;
            if (we) begin
                e.st = 1;
                modelRam[key] = data;
            end else begin
                modelDout = modelRam.exists(key) ? modelRam[key] : 16'h0000;
            end
        end
        e.ackCycle = issue + 2 + waitCycles;
        e.dout     = modelDout;
        return e;
    endfunction

    // Issue one access, scramble the bus once it is latched, and hold REQ until ACK.
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] data, input bit keepReq);
        int  issue;
        bit  seen;
        REQ  = 1'b1;
        WE   = we;
        ADDR = addr;
        D_IN = data;
        issue = dutInDone ? cycleCount + 1 : cycleCount;
        expQ.push_back(predict(we, addr, data, issue));
        repeat (dutInDone ? 2 : 1) @(negedge CLK);
        WE   = 1'($urandom_range(0, 1));
        ADDR = 16'($urandom);
        D_IN = 16'($urandom);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (ACK) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
            expQ.delete();
            REQ = 1'b0;
            dutInDone = 0;
        end else begin
            if (!keepReq) REQ = 1'b0;
            dutInDone = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
        dutInDone = 0;
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            if (ACK) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("ack_cycle", 32'(cycleCount), 32'(e.ackCycle));
                    checkOutput("d_out", 32'(D_OUT), 32'(e.dout));
                    checkOutput("err", 32'(ERR), 32'(e.err));
                    checkOutput("ram_st", 32'(RAM_ST), 32'(e.st));
                    if (e.isRam) checkOutput("ram_a", 32'(RAM_A), 32'(e.ramA));
                    if (e.isRom) checkOutput("rom_a", 32'(ROM_A), 32'(e.romA));
                    if (e.st)    checkOutput("ram_x", 32'(RAM_X), 32'(e.ramX));
                end
            end else begin
                checkOutput("err_without_ack", 32'(ERR), 32'd0);
                checkOutput("st_without_ack", 32'(RAM_ST), 32'd0);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"},   32'(ACK),    32'd0);
        checkOutput({tag, "_err"},   32'(ERR),    32'd0);
        checkOutput({tag, "_st"},    32'(RAM_ST), 32'd0);
        checkOutput({tag, "_d_out"}, 32'(D_OUT),  32'd0);
        checkOutput({tag, "_rom_a"}, 32'(ROM_A),  32'd0);
        checkOutput({tag, "_ram_a"}, 32'(RAM_A),  32'd0);
        checkOutput({tag, "_ram_x"}, 32'(RAM_X),  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int ackSeen;
        bit keep;
        bit prevKeep;
        int pick;
        logic [15:0] a;
        for (int i = 0; i < 262144; i++) ramMem[i] = 16'h0000;
        RST_N = 1'b0;
        REQ   = 1'b0;
        WE    = 1'b0;
        ADDR  = 16'h0000;
        D_IN  = 16'h0000;
        #3;
        checkAllZero("reset");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        dutInDone = 0;

        applyStimulus(1'b0, 16'h0100, 16'h0000, 0);
        applyStimulus(1'b1, 16'h8000, 16'h1234, 0);
        idle(1);
        applyStimulus(1'b0, 16'h8000, 16'h0000, 0);
        applyStimulus(1'b1, 16'hFFFF, 16'h0003, 0);
        idle(2);
        applyStimulus(1'b1, 16'h2000, 16'hCAFE, 0);
        applyStimulus(1'b0, 16'h2000, 16'h0000, 0);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 0);
        applyStimulus(1'b1, 16'h1FFF, 16'hFFFF, 0);
        idle(1);
        applyStimulus(1'b0, 16'h4000, 16'h0000, 1);
        applyStimulus(1'b0, 16'h2000, 16'h0000, 1);
        applyStimulus(1'b0, 16'h8000, 16'h0000, 0);

        // Abort a ROM read while it is still counting its wait cycle.
        @(negedge CLK);
        dutInDone = 0;
        REQ  = 1'b1;
        WE   = 1'b0;
        ADDR = 16'h0100;
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 checkAllZero("abort");
        REQ = 1'b0;
        modelBank = 0;
        modelDout = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        ackSeen = 0;
        repeat (5) begin
            @(negedge CLK);
            if (ACK) ackSeen++;
        end
        checkOutput("no_ack_after_abort", 32'(ackSeen), 32'd0);
        dutInDone = 0;
        applyStimulus(1'b0, 16'h0100, 16'h0000, 0);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 0);

        prevKeep = 0;
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            if (pick < 2)      a = 16'hFFFF;
            else if (pick < 5) a = 16'($urandom_range(0, 16'h1FFF));
            else               a = 16'($urandom_range(16'h2000, 16'hFFFE));
            keep = (n != 299) && ($urandom_range(0, 2) == 0);
            if (!prevKeep && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 3));
            applyStimulus(1'($urandom_range(0, 1)), a, 16'($urandom), keep);
            prevKeep = keep;
        end

        idle(5);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
